// File: rtl/mips_cpu.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu
// Brief    : Single-cycle 32-bit MIPS subset CPU (PC, imem, regfile, ALU, dmem).
//            Optional macro CPU_JUMP_EN enables the j instruction (opcode 0x02).
// Revision : 1.0 - initial release
// ============================================================================

module mips_imem #(
    parameter int DEPTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [31:0]              i_wdata,
    input  logic [31:0]              i_addr,
    output logic [31:0]              o_rdata
);
    localparam int c_AW = $clog2(DEPTH);

    logic [31:0] data [DEPTH];
    logic        w_unused;

    // Load port exists for program download; the fetch side is purely combinational.
    always_ff @(posedge i_clk) begin
        if (i_we) data[i_waddr] <= i_wdata;
    end

    assign o_rdata  = data[i_addr[c_AW+1:2]];
    assign w_unused = &{1'b0, i_addr[31:c_AW+2], i_addr[1:0]};
endmodule

module mips_regfile (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);
    logic [31:0] data [32];

    always_ff @(posedge i_clk) begin
        if (i_we && (i_waddr != 5'd0)) data[i_waddr] <= i_wdata;
    end

    assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : data[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : data[i_raddr_b];
endmodule

module mips_dmem #(
    parameter int DEPTH = 64
) (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    localparam int c_AW = $clog2(DEPTH);

    logic [31:0]     data [DEPTH];
    logic [c_AW-1:0] w_idx;
    logic            w_unused;

    // Upper address bits are dropped so accesses wrap modulo the depth.
    assign w_idx    = i_addr[c_AW+1:2];
    assign w_unused = &{1'b0, i_addr[31:c_AW+2], i_addr[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_we) data[w_idx] <= i_wdata;
    end

    assign o_rdata = data[w_idx];
endmodule

module mips_cpu #(
    parameter int INSTR_MEM_SIZE = 32,
    parameter int DATA_MEM_SIZE  = 64
) (
    input  logic clock,
    input  logic reset
);
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
`ifdef CPU_JUMP_EN
    localparam logic [5:0] c_OP_J     = 6'h02;
`endif
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    logic [31:0] r_pc;
    logic [31:0] w_instr, w_pc4, w_pc_next, w_sext, w_zext, w_ea;
    logic [31:0] w_rs_val, w_rt_val, w_mem_rdata, w_result;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_dst;
    logic        w_reg_we, w_mem_we, w_take, w_jump;

    assign w_op    = w_instr[31:26];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];
    assign w_funct = w_instr[5:0];
    assign w_sext  = {{16{w_instr[15]}}, w_instr[15:0]};
    assign w_zext  = {16'd0, w_instr[15:0]};
    assign w_ea    = w_rs_val + w_sext;
    assign w_pc4   = r_pc + 32'd4;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_pc <= 32'd0;
        else        r_pc <= w_pc_next;
    end

    always_comb begin
        w_result = 32'd0;
        w_dst    = w_rd;
        w_reg_we = 1'b0;
        w_mem_we = 1'b0;
        w_take   = 1'b0;
        w_jump   = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                w_reg_we = 1'b1;
                case (w_funct)
                    c_FN_ADD: w_result = w_rs_val + w_rt_val;
                    c_FN_SUB: w_result = w_rs_val - w_rt_val;
                    c_FN_AND: w_result = w_rs_val & w_rt_val;
                    c_FN_OR:  w_result = w_rs_val | w_rt_val;
                    c_FN_NOR: w_result = ~(w_rs_val | w_rt_val);
                    c_FN_SLT: w_result = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)};
                    default:  w_reg_we = 1'b0;
                endcase
            end
            c_OP_ADDI: begin w_dst = w_rt; w_reg_we = 1'b1; w_result = w_ea;              end
            c_OP_ANDI: begin w_dst = w_rt; w_reg_we = 1'b1; w_result = w_rs_val & w_zext; end
            c_OP_ORI:  begin w_dst = w_rt; w_reg_we = 1'b1; w_result = w_rs_val | w_zext; end
            c_OP_LW:   begin w_dst = w_rt; w_reg_we = 1'b1; w_result = w_mem_rdata;       end
            c_OP_SW:   w_mem_we = 1'b1;
            c_OP_BEQ:  w_take = (w_rs_val == w_rt_val);
            c_OP_BNE:  w_take = (w_rs_val != w_rt_val);
`ifdef CPU_JUMP_EN
            c_OP_J:    w_jump = 1'b1;
`endif
            default: ;
        endcase
    end

    assign w_pc_next = w_jump ? {w_pc4[31:28], w_instr[25:0], 2'b00} :
                       w_take ? (w_pc4 + {w_sext[29:0], 2'b00}) : w_pc4;

    mips_imem #(.DEPTH(INSTR_MEM_SIZE)) InstructionMemory_0 (
        .i_clk   (clock),
        .i_we    (1'b0),
        .i_waddr ('0),
        .i_wdata (32'd0),
        .i_addr  (r_pc),
        .o_rdata (w_instr)
    );

    // Writes are qualified with reset so an edge during reset commits nothing.
    mips_regfile Registers_0 (
        .i_clk     (clock),
        .i_we      (w_reg_we & reset),
        .i_waddr   (w_dst),
        .i_wdata   (w_result),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rs_val),
        .o_rdata_b (w_rt_val)
    );

    mips_dmem #(.DEPTH(DATA_MEM_SIZE)) DataMemory_0 (
        .i_clk   (clock),
        .i_we    (w_mem_we & reset),
        .i_addr  (w_ea),
        .i_wdata (w_rt_val),
        .o_rdata (w_mem_rdata)
    );
endmodule

`default_nettype wire

// File: tb/tb_mips_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu
// Brief    : Directed self-checking bench for mips_cpu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu;
    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    mips_cpu #(.INSTR_MEM_SIZE(32), .DATA_MEM_SIZE(64)) dut (
        .clock (clock),
        .reset (reset)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Holds the core in reset and reinitialises program, registers (reg[i]=i) and data.
    task automatic hold_reset();
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 32; i++) dut.InstructionMemory_0.data[i] <= 32'd0;
        for (int i = 0; i < 32; i++) dut.Registers_0.data[i] <= i;
        for (int i = 0; i < 64; i++) dut.DataMemory_0.data[i] <= 32'hDEADBEEF;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        hold_reset();
        dut.InstructionMemory_0.data[0] <= rtype(5'd9, 5'd10, 5'd8, 6'h20);
        dut.InstructionMemory_0.data[1] <= rtype(5'd9, 5'd10, 5'd20, 6'h20);
        step(2);
        chk("reset_pc_held", dut.r_pc, 32'd0);
        release_reset();
        chk("reset_pc_release", dut.r_pc, 32'd0);
        step(1);
        chk("reset_first_pc", dut.r_pc, 32'd4);
        chk("reset_first_exec", dut.Registers_0.data[8], 32'd19);
        #2 reset = 1'b0;
        #1;
        chk("reset_async_pc", dut.r_pc, 32'd0);
        step(1);
        chk("reset_no_write", dut.Registers_0.data[20], 32'd20);
        chk("reset_pc_stays", dut.r_pc, 32'd0);
    endtask

    task automatic test_rtype();
        hold_reset();
        dut.Registers_0.data[22] <= 32'hFFFFFFFF;
        dut.InstructionMemory_0.data[0]  <= rtype(5'd9,  5'd10, 5'd8,  6'h20);
        dut.InstructionMemory_0.data[1]  <= rtype(5'd10, 5'd9,  5'd11, 6'h22);
        dut.InstructionMemory_0.data[2]  <= rtype(5'd10, 5'd9,  5'd12, 6'h2A);
        dut.InstructionMemory_0.data[3]  <= rtype(5'd9,  5'd9,  5'd0,  6'h20);
        dut.InstructionMemory_0.data[4]  <= rtype(5'd0,  5'd9,  5'd24, 6'h20);
        dut.InstructionMemory_0.data[5]  <= rtype(5'd9,  5'd10, 5'd16, 6'h24);
        dut.InstructionMemory_0.data[6]  <= rtype(5'd9,  5'd10, 5'd17, 6'h25);
        dut.InstructionMemory_0.data[7]  <= rtype(5'd9,  5'd10, 5'd18, 6'h27);
        dut.InstructionMemory_0.data[8]  <= rtype(5'd22, 5'd1,  5'd19, 6'h2A);
        dut.InstructionMemory_0.data[9]  <= rtype(5'd9,  5'd10, 5'd23, 6'h3F);
        dut.InstructionMemory_0.data[10] <= rtype(5'd9,  5'd9,  5'd9,  6'h20);
        release_reset();
        step(11);
        chk("rtype_pc", dut.r_pc, 32'd44);
        chk("add", dut.Registers_0.data[8], 32'd19);
        chk("sub", dut.Registers_0.data[11], 32'd1);
        chk("slt_false", dut.Registers_0.data[12], 32'd0);
        chk("zero_reg", dut.Registers_0.data[0], 32'd0);
        chk("zero_read", dut.Registers_0.data[24], 32'd9);
        chk("and", dut.Registers_0.data[16], 32'd8);
        chk("or", dut.Registers_0.data[17], 32'd11);
        chk("nor", dut.Registers_0.data[18], 32'hFFFFFFF4);
        chk("slt_signed", dut.Registers_0.data[19], 32'd1);
        chk("bad_funct", dut.Registers_0.data[23], 32'd23);
        chk("read_old", dut.Registers_0.data[9], 32'd18);
    endtask

    task automatic test_memory();
        hold_reset();
        dut.InstructionMemory_0.data[0] <= itype(6'h2B, 5'd0,  5'd9,  16'd8);
        dut.InstructionMemory_0.data[1] <= itype(6'h23, 5'd0,  5'd13, 16'd8);
        dut.InstructionMemory_0.data[2] <= itype(6'h2B, 5'd0,  5'd10, 16'd256);
        dut.InstructionMemory_0.data[3] <= itype(6'h23, 5'd0,  5'd14, 16'd3);
        dut.InstructionMemory_0.data[4] <= itype(6'h2B, 5'd12, 5'd11, 16'hFFFC);
        release_reset();
        step(1);
        chk("sw", dut.DataMemory_0.data[2], 32'd9);
        step(1);
        chk("lw", dut.Registers_0.data[13], 32'd9);
        step(1);
        chk("sw_wrap", dut.DataMemory_0.data[0], 32'd10);
        step(1);
        chk("lw_unaligned", dut.Registers_0.data[14], 32'd10);
        step(1);
        chk("sw_neg_offset", dut.DataMemory_0.data[2], 32'd11);
    endtask

    task automatic test_branch();
        hold_reset();
        dut.InstructionMemory_0.data[0] <= itype(6'h04, 5'd4, 5'd4,  16'd2);
        dut.InstructionMemory_0.data[1] <= itype(6'h08, 5'd0, 5'd25, 16'd7);
        dut.InstructionMemory_0.data[2] <= itype(6'h08, 5'd0, 5'd26, 16'd7);
        release_reset();
        step(1);
        chk("beq_taken_pc", dut.r_pc, 32'd12);
        step(1);
        chk("beq_after_pc", dut.r_pc, 32'd16);
        chk("beq_skip1", dut.Registers_0.data[25], 32'd25);
        chk("beq_skip2", dut.Registers_0.data[26], 32'd26);

        hold_reset();
        dut.InstructionMemory_0.data[0] <= itype(6'h04, 5'd4, 5'd5, 16'd2);
        dut.InstructionMemory_0.data[1] <= itype(6'h05, 5'd4, 5'd4, 16'd5);
        dut.InstructionMemory_0.data[2] <= itype(6'h05, 5'd4, 5'd5, 16'hFFFF);
        release_reset();
        step(1);
        chk("beq_not_taken", dut.r_pc, 32'd4);
        step(1);
        chk("bne_not_taken", dut.r_pc, 32'd8);
        step(1);
        chk("bne_loop1", dut.r_pc, 32'd8);
        step(1);
        chk("bne_loop2", dut.r_pc, 32'd8);
    endtask

    task automatic test_immediate();
        hold_reset();
        dut.Registers_0.data[22] <= 32'hFFFFFFFF;
        dut.InstructionMemory_0.data[0] <= itype(6'h08, 5'd1,  5'd14, 16'hFFFD);
        dut.InstructionMemory_0.data[1] <= itype(6'h0D, 5'd0,  5'd15, 16'h8000);
        dut.InstructionMemory_0.data[2] <= itype(6'h0C, 5'd22, 5'd16, 16'h8001);
        dut.InstructionMemory_0.data[3] <= itype(6'h08, 5'd0,  5'd17, 16'h7FFF);
        release_reset();
        step(4);
        chk("addi_neg", dut.Registers_0.data[14], 32'hFFFFFFFE);
        chk("ori_zext", dut.Registers_0.data[15], 32'h00008000);
        chk("andi_zext", dut.Registers_0.data[16], 32'h00008001);
        chk("addi_pos", dut.Registers_0.data[17], 32'h00007FFF);
    endtask

    task automatic test_jump_nop();
        logic [31:0] exp_pc;
`ifdef CPU_JUMP_EN
        exp_pc = 32'd20;
`else
        exp_pc = 32'd4;
`endif
        hold_reset();
        dut.InstructionMemory_0.data[0] <= {6'h02, 26'd5};
        dut.InstructionMemory_0.data[1] <= itype(6'h3F, 5'd1, 5'd7, 16'd4);
        dut.InstructionMemory_0.data[5] <= itype(6'h3F, 5'd1, 5'd7, 16'd4);
        release_reset();
        step(1);
        chk("jump_pc", dut.r_pc, exp_pc);
        chk("jump_no_write", dut.Registers_0.data[2], 32'd2);
        step(1);
        chk("nop_op3f_pc", dut.r_pc, exp_pc + 32'd4);
        chk("nop_op3f_reg", dut.Registers_0.data[7], 32'd7);
        chk("nop_op3f_mem", dut.DataMemory_0.data[1], 32'hDEADBEEF);
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_rtype();
        test_memory();
        test_branch();
        test_immediate();
        test_jump_nop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
